// File: rtl/axi_read_port_arbiter.sv
// Two-requester arbiter in front of a single AXI burst read master. Latches one
// request per requester, issues bursts one at a time, and steers R-channel strobes to the owner.
module axi_read_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_start_read,
  input  logic [ADDR_WIDTH-1:0] req0_read_addr,
  input  logic [31:0]           req0_read_len,
  input  logic [2:0]            req0_read_size,
  input  logic [1:0]            req0_read_burst,
  output logic                  req0_rvalid,
  output logic                  req0_rlast,
  output logic                  req0_arready,
  output logic                  req0_pending,
  output logic                  req0_done,
  input  logic                  req1_start_read,
  input  logic [ADDR_WIDTH-1:0] req1_read_addr,
  input  logic [31:0]           req1_read_len,
  input  logic [2:0]            req1_read_size,
  input  logic [1:0]            req1_read_burst,
  output logic                  req1_rvalid,
  output logic                  req1_rlast,
  output logic                  req1_arready,
  output logic                  req1_pending,
  output logic                  req1_done,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  req_overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t state_reg, state_next;

  logic                  owner_reg;
  logic                  last_grant_reg;
  logic [1:0]            grant_reg;
  logic [1:0]            pending_reg;
  logic [1:0]            done_reg;
  logic                  overflow_reg;
  logic [ADDR_WIDTH-1:0] slot_addr_reg  [2];
  logic [31:0]           slot_len_reg   [2];
  logic [2:0]            slot_size_reg  [2];
  logic [1:0]            slot_burst_reg [2];
  logic [ADDR_WIDTH-1:0] read_addr_reg;
  logic [31:0]           read_len_reg;
  logic [2:0]            read_size_reg;
  logic [1:0]            read_burst_reg;

  logic [1:0]            start_vec;
  logic [ADDR_WIDTH-1:0] in_addr  [2];
  logic [31:0]           in_len   [2];
  logic [2:0]            in_size  [2];
  logic [1:0]            in_burst [2];
  logic [1:0]            reject;
  logic [1:0]            accept;
  logic [1:0]            rvalid_vec, rlast_vec, arready_vec;
  logic                  last_beat;
  logic                  take;
  logic                  winner;

  assign start_vec   = {req1_start_read, req0_start_read};
  assign in_addr[0]  = req0_read_addr;
  assign in_addr[1]  = req1_read_addr;
  assign in_len[0]   = req0_read_len;
  assign in_len[1]   = req1_read_len;
  assign in_size[0]  = req0_read_size;
  assign in_size[1]  = req1_read_size;
  assign in_burst[0] = req0_read_burst;
  assign in_burst[1] = req1_read_burst;

  assign last_beat = (state_reg == BURST) && rvalid && rready && rlast;
  assign take      = (state_reg == IDLE) && (|pending_reg);
  // With both pending, the requester that did not win last time goes next.
  assign winner    = (pending_reg == 2'b11) ? ~last_grant_reg : pending_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic owned_active;

      // A burst finishing this cycle frees its owner to queue the next request.
      assign owned_active = (state_reg != IDLE) && (owner_reg == 1'(gi)) && !last_beat;
      assign reject[gi]   = start_vec[gi] && (pending_reg[gi] || owned_active);
      assign accept[gi]   = start_vec[gi] && !reject[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg[gi]    <= 1'b0;
          slot_addr_reg[gi]  <= '0;
          slot_len_reg[gi]   <= '0;
          slot_size_reg[gi]  <= '0;
          slot_burst_reg[gi] <= '0;
        end else if (accept[gi]) begin
          pending_reg[gi]    <= 1'b1;
          slot_addr_reg[gi]  <= in_addr[gi];
          slot_len_reg[gi]   <= in_len[gi];
          slot_size_reg[gi]  <= in_size[gi];
          slot_burst_reg[gi] <= in_burst[gi];
        end else if (take && (winner == 1'(gi))) begin
          pending_reg[gi] <= 1'b0;
        end
      end

      assign rvalid_vec[gi]  = (state_reg == BURST) && (owner_reg == 1'(gi)) && rvalid;
      assign rlast_vec[gi]   = (state_reg == BURST) && (owner_reg == 1'(gi)) && rlast;
      assign arready_vec[gi] = (state_reg == BURST) && (owner_reg == 1'(gi)) && arready;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = ISSUE;
      ISSUE:   state_next = BURST;
      BURST:   if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_read = (state_reg == ISSUE);
    busy       = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      grant_reg      <= 2'b00;
      done_reg       <= 2'b00;
      overflow_reg   <= 1'b0;
      read_addr_reg  <= '0;
      read_len_reg   <= '0;
      read_size_reg  <= '0;
      read_burst_reg <= '0;
    end else begin
      done_reg <= last_beat ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
      if (|reject) overflow_reg <= 1'b1;
      if (take) begin
        owner_reg      <= winner;
        last_grant_reg <= winner;
        grant_reg      <= winner ? 2'b10 : 2'b01;
        read_addr_reg  <= slot_addr_reg[winner];
        read_len_reg   <= slot_len_reg[winner];
        read_size_reg  <= slot_size_reg[winner];
        read_burst_reg <= slot_burst_reg[winner];
      end else if (last_beat) begin
        grant_reg <= 2'b00;
      end
    end
  end

  assign req0_rvalid  = rvalid_vec[0];
  assign req1_rvalid  = rvalid_vec[1];
  assign req0_rlast   = rlast_vec[0];
  assign req1_rlast   = rlast_vec[1];
  assign req0_arready = arready_vec[0];
  assign req1_arready = arready_vec[1];
  assign req0_pending = pending_reg[0];
  assign req1_pending = pending_reg[1];
  assign req0_done    = done_reg[0];
  assign req1_done    = done_reg[1];
  assign grant        = grant_reg;
  assign req_overflow = overflow_reg;
  assign read_addr    = read_addr_reg;
  assign read_len     = read_len_reg;
  assign read_size    = read_size_reg;
  assign read_burst   = read_burst_reg;

endmodule
